// File: rtl/neuron_input_sequencer.sv
// -----------------------------------------------------------------------------
// neuron_input_sequencer
//
// Upstream controller for math_calculation_core. For one neuron it walks N
// input/weight pairs out of the layer input and weight buffers, presents each
// pair to the core with a calculator_start pulse and waits for
// calculator_valid. After the last pair it pulses sigmoid_start and captures
// the activated result on sigmoid_valid. Each wait is bounded by
// TIMEOUT_CYCLES; an expired wait or a zero-length neuron ends with done and
// error together.
//
// Ports
//   clk, reset_b         clock, asynchronous active-low reset
//   start                1-cycle pulse that begins a neuron (ignored while busy)
//   num_inputs           pair count, sampled on an accepted start
//   in_base_addr         input buffer base address, sampled on an accepted start
//   wt_base_addr         weight buffer base address, sampled on an accepted start
//   in_rd_en/in_rd_addr  input buffer read port (data returns one cycle later)
//   in_rd_data           input buffer read data
//   wt_rd_en/wt_rd_addr  weight buffer read port (data returns one cycle later)
//   wt_rd_data           weight buffer read data
//   calculator_start     1-cycle pulse per pair to the core
//   sigmoid_start        1-cycle pulse to the core after the last pair
//   input_value          registered input word presented to the core
//   weight_value         registered weight word presented to the core
//   calculator_valid     core has accumulated the presented pair
//   sigmoid_valid        calculation_result is valid this cycle
//   calculation_result   activated neuron value from the core
//   busy                 high from an accepted start until done
//   done                 1-cycle pulse when the neuron finishes
//   error                qualifies done: timeout or num_inputs == 0
//   neuron_result        last successfully captured result
// -----------------------------------------------------------------------------
module neuron_input_sequencer #(
  parameter int NPU_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset_b,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      num_inputs,
  input  logic [ADDR_WIDTH-1:0]     in_base_addr,
  input  logic [ADDR_WIDTH-1:0]     wt_base_addr,
  output logic                      in_rd_en,
  output logic [ADDR_WIDTH-1:0]     in_rd_addr,
  input  logic [NPU_DATA_WIDTH-1:0] in_rd_data,
  output logic                      wt_rd_en,
  output logic [ADDR_WIDTH-1:0]     wt_rd_addr,
  input  logic [NPU_DATA_WIDTH-1:0] wt_rd_data,
  output logic                      calculator_start,
  output logic                      sigmoid_start,
  output logic [NPU_DATA_WIDTH-1:0] input_value,
  output logic [NPU_DATA_WIDTH-1:0] weight_value,
  input  logic                      calculator_valid,
  input  logic                      sigmoid_valid,
  input  logic [NPU_DATA_WIDTH-1:0] calculation_result,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [NPU_DATA_WIDTH-1:0] neuron_result
);

  localparam int TIMER_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  // The timer starts at 0 on wait entry, so the last allowed waiting cycle
  // is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    MAC_START,
    MAC_WAIT,
    ACT_START,
    ACT_WAIT,
    DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_WIDTH-1:0]    num_q;
  logic [CNT_WIDTH-1:0]    idx;
  logic [ADDR_WIDTH-1:0]   in_base_q;
  logic [ADDR_WIDTH-1:0]   wt_base_q;
  logic [TIMER_WIDTH-1:0]  timer;
  logic                    err_q;
  logic                    last_pair;
  logic                    timer_expired;

  assign last_pair     = (CNT_WIDTH'(idx + 1'b1) == num_q);
  assign timer_expired = (timer == TIMER_LAST);

  // Buffer addresses wrap naturally at 2^ADDR_WIDTH.
  assign in_rd_addr = in_base_q + ADDR_WIDTH'(idx);
  assign wt_rd_addr = wt_base_q + ADDR_WIDTH'(idx);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge, independent of block order.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and Moore outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next       = state;
    in_rd_en         = 1'b0;
    wt_rd_en         = 1'b0;
    calculator_start = 1'b0;
    sigmoid_start    = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    error            = 1'b0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_next = (num_inputs == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        in_rd_en   = 1'b1;
        wt_rd_en   = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        state_next = MAC_START;
      end
      MAC_START: begin
        calculator_start = 1'b1;
        state_next       = MAC_WAIT;
      end
      MAC_WAIT: begin
        // A valid on the final allowed cycle takes priority over the timeout.
        if (calculator_valid) begin
          state_next = last_pair ? ACT_START : FETCH;
        end else if (timer_expired) begin
          state_next = DONE;
        end
      end
      ACT_START: begin
        sigmoid_start = 1'b1;
        state_next    = ACT_WAIT;
      end
      ACT_WAIT: begin
        if (sigmoid_valid || timer_expired) begin
          state_next = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; the next neuron can only
        // be accepted from IDLE.
        busy       = 1'b0;
        done       = 1'b1;
        error      = err_q;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: job parameters, pair index, wait timer and captured values
  // ---------------------------------------------------------------------------
  // NOTE: these are plain registers rather than a memory array, so they all
  // take the asynchronous reset and come up as zero.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      num_q         <= '0;
      idx           <= '0;
      in_base_q     <= '0;
      wt_base_q     <= '0;
      timer         <= '0;
      err_q         <= 1'b0;
      input_value   <= '0;
      weight_value  <= '0;
      neuron_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            num_q     <= num_inputs;
            in_base_q <= in_base_addr;
            wt_base_q <= wt_base_addr;
            idx       <= '0;
            err_q     <= (num_inputs == '0);
          end
        end
        LOAD: begin
          input_value  <= in_rd_data;
          weight_value <= wt_rd_data;
        end
        MAC_START, ACT_START: begin
          timer <= '0;
        end
        MAC_WAIT: begin
          if (calculator_valid) begin
            idx <= CNT_WIDTH'(idx + 1'b1);
          end else begin
            timer <= TIMER_WIDTH'(timer + 1'b1);
            if (timer_expired) begin
              err_q <= 1'b1;
            end
          end
        end
        ACT_WAIT: begin
          if (sigmoid_valid) begin
            neuron_result <= calculation_result;
          end else begin
            timer <= TIMER_WIDTH'(timer + 1'b1);
            if (timer_expired) begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_neuron_input_sequencer
//
// Drives neuron_input_sequencer with directed and randomized neurons. Buffer
// memories and a latency-configurable core model sit around the DUT; a
// negedge monitor logs every read address, presented pair, start pulse and
// done. Expected behaviour is derived from the pair list a neuron should walk
// (base + i mod 256) and the outcome that follows from the core's behaviour.
// -----------------------------------------------------------------------------
module tb_neuron_input_sequencer;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CW = 8;
  localparam int TO = 255;

  logic          clk = 1'b0;
  logic          reset_b;
  logic          start;
  logic [CW-1:0] num_inputs;
  logic [AW-1:0] in_base_addr;
  logic [AW-1:0] wt_base_addr;
  logic          in_rd_en;
  logic [AW-1:0] in_rd_addr;
  logic [DW-1:0] in_rd_data;
  logic          wt_rd_en;
  logic [AW-1:0] wt_rd_addr;
  logic [DW-1:0] wt_rd_data;
  logic          calculator_start;
  logic          sigmoid_start;
  logic [DW-1:0] input_value;
  logic [DW-1:0] weight_value;
  logic          calculator_valid;
  logic          sigmoid_valid;
  logic [DW-1:0] calculation_result;
  logic          busy;
  logic          done;
  logic          error;
  logic [DW-1:0] neuron_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_input_sequencer #(
    .NPU_DATA_WIDTH(DW),
    .ADDR_WIDTH    (AW),
    .CNT_WIDTH     (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk               (clk),
    .reset_b           (reset_b),
    .start             (start),
    .num_inputs        (num_inputs),
    .in_base_addr      (in_base_addr),
    .wt_base_addr      (wt_base_addr),
    .in_rd_en          (in_rd_en),
    .in_rd_addr        (in_rd_addr),
    .in_rd_data        (in_rd_data),
    .wt_rd_en          (wt_rd_en),
    .wt_rd_addr        (wt_rd_addr),
    .wt_rd_data        (wt_rd_data),
    .calculator_start  (calculator_start),
    .sigmoid_start     (sigmoid_start),
    .input_value       (input_value),
    .weight_value      (weight_value),
    .calculator_valid  (calculator_valid),
    .sigmoid_valid     (sigmoid_valid),
    .calculation_result(calculation_result),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .neuron_result     (neuron_result)
  );

  // ---------------------------------------------------------------------------
  // Buffer memories: one-cycle read latency, junk when not strobed
  // ---------------------------------------------------------------------------
  logic [DW-1:0] in_mem [256];
  logic [DW-1:0] wt_mem [256];

  always @(posedge clk) begin
    in_rd_data <= in_rd_en ? in_mem[in_rd_addr] : 16'hBAD0;
    wt_rd_data <= wt_rd_en ? wt_mem[wt_rd_addr] : 16'hBAD1;
  end

  // ---------------------------------------------------------------------------
  // Core model: valid arrives lat cycles after the start pulse
  // ---------------------------------------------------------------------------
  int            calc_lat = 1;
  int            sig_lat  = 1;
  bit            calc_ok  = 1'b1;
  bit            sig_ok   = 1'b1;
  logic [DW-1:0] sig_value = '0;
  int            calc_cnt = 0;
  int            sig_cnt  = 0;

  always @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      calc_cnt <= 0;
      sig_cnt  <= 0;
    end else begin
      if (calculator_start)  calc_cnt <= calc_lat;
      else if (calc_cnt != 0) calc_cnt <= calc_cnt - 1;
      if (sigmoid_start)     sig_cnt <= sig_lat;
      else if (sig_cnt != 0) sig_cnt <= sig_cnt - 1;
    end
  end

  assign calculator_valid   = calc_ok && (calc_cnt == 1);
  assign sigmoid_valid      = sig_ok && (sig_cnt == 1);
  assign calculation_result = sigmoid_valid ? sig_value : 16'hDEAD;

  // ---------------------------------------------------------------------------
  // Monitor: cycle-stamped log of everything the DUT emits
  // ---------------------------------------------------------------------------
  int          cyc = 0;
  int          rd_in_q[$];
  int          rd_wt_q[$];
  logic [31:0] pair_q[$];
  int          cs_cyc_q[$];
  int          ss_cyc_q[$];
  int          done_count = 0;
  int          done_cyc = 0;
  logic        done_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (in_rd_en) rd_in_q.push_back(int'(in_rd_addr));
    if (wt_rd_en) rd_wt_q.push_back(int'(wt_rd_addr));
    if (calculator_start) begin
      pair_q.push_back({input_value, weight_value});
      cs_cyc_q.push_back(cyc);
    end
    if (sigmoid_start) ss_cyc_q.push_back(cyc);
    if (done) begin
      done_count <= done_count + 1;
      done_cyc   <= cyc;
      done_err   <= error;
    end
  end

  logic [DW-1:0] exp_result = '0;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Launch one neuron, wait for its done and compare the whole log against
  // the pair walk the neuron should have made.
  task automatic run_neuron(input string tag, input int num, input logic [AW-1:0] inb,
                            input logic [AW-1:0] wtb, input int lat, input int slat,
                            input bit cok, input bit sok, input logic [DW-1:0] sval);
    int            b_in, b_wt, b_pair, b_cs, b_ss, b_done, start_c, k;
    int            exp_reads, exp_pairs, exp_sig;
    bit            exp_err;
    logic [AW-1:0] ia, wa;
    b_in   = rd_in_q.size();
    b_wt   = rd_wt_q.size();
    b_pair = pair_q.size();
    b_cs   = cs_cyc_q.size();
    b_ss   = ss_cyc_q.size();
    b_done = done_count;
    calc_lat  = lat;
    sig_lat   = slat;
    calc_ok   = cok;
    sig_ok    = sok;
    sig_value = sval;

    @(negedge clk);
    start        = 1'b1;
    num_inputs   = CW'(num);
    in_base_addr = inb;
    wt_base_addr = wtb;
    start_c      = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, busy, (num != 0));

    k = 0;
    while (done_count == b_done && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check({tag, " done_within_budget"}, (done_count != b_done), 1'b1);
    repeat (3) @(negedge clk);

    if (num == 0) begin
      exp_reads = 0; exp_pairs = 0; exp_sig = 0; exp_err = 1'b1;
    end else if (!cok) begin
      exp_reads = 1; exp_pairs = 1; exp_sig = 0; exp_err = 1'b1;
    end else if (!sok) begin
      exp_reads = num; exp_pairs = num; exp_sig = 1; exp_err = 1'b1;
    end else begin
      exp_reads = num; exp_pairs = num; exp_sig = 1; exp_err = 1'b0;
      exp_result = sval;
    end

    check({tag, " done_count"}, done_count - b_done, 1);
    check({tag, " error"}, done_err, exp_err);
    check({tag, " neuron_result"}, neuron_result, exp_result);
    check({tag, " busy_idle"}, busy, 1'b0);
    check({tag, " in_reads"}, rd_in_q.size() - b_in, exp_reads);
    check({tag, " wt_reads"}, rd_wt_q.size() - b_wt, exp_reads);
    check({tag, " calc_starts"}, pair_q.size() - b_pair, exp_pairs);
    check({tag, " sig_starts"}, ss_cyc_q.size() - b_ss, exp_sig);

    for (int i = 0; i < exp_reads; i++) begin
      ia = AW'(inb + AW'(i));
      wa = AW'(wtb + AW'(i));
      if (b_in + i < rd_in_q.size()) check({tag, " in_addr"}, rd_in_q[b_in + i], int'(ia));
      if (b_wt + i < rd_wt_q.size()) check({tag, " wt_addr"}, rd_wt_q[b_wt + i], int'(wa));
      if (b_pair + i < pair_q.size()) check({tag, " pair"}, pair_q[b_pair + i], {in_mem[ia], wt_mem[wa]});
    end

    // Start in cycle c, DONE state in cycle c+1.
    if (num == 0) check({tag, " zero_done_cycle"}, done_cyc, start_c + 1);
    // A timed-out wait entered at cycle m ends with done at m + TO.
    if (num != 0 && !cok && b_cs < cs_cyc_q.size())
      check({tag, " mac_timeout_cycle"}, done_cyc, cs_cyc_q[b_cs] + 1 + TO);
    if (num != 0 && cok && !sok && b_ss < ss_cyc_q.size())
      check({tag, " act_timeout_cycle"}, done_cyc, ss_cyc_q[b_ss] + 1 + TO);
  endtask

  initial begin
    int b_done, b_in, b_wt, b_cs, k;
    logic [DW-1:0] spam_val;

    for (int i = 0; i < 256; i++) begin
      in_mem[i] = DW'($urandom);
      wt_mem[i] = DW'($urandom);
    end
    in_mem[8'h10] = 16'h0100; in_mem[8'h11] = 16'h0200; in_mem[8'h12] = 16'h0300;
    wt_mem[8'h20] = 16'h0080; wt_mem[8'h21] = 16'h0040; wt_mem[8'h22] = 16'h0020;

    reset_b      = 1'b0;
    start        = 1'b0;
    num_inputs   = '0;
    in_base_addr = '0;
    wt_base_addr = '0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset error", error, 1'b0);
    check("reset in_rd_en", in_rd_en, 1'b0);
    check("reset calc_start", calculator_start, 1'b0);
    check("reset neuron_result", neuron_result, 16'h0000);
    check("reset input_value", input_value, 16'h0000);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // Directed cases.
    run_neuron("basic3", 3, 8'h10, 8'h20, 2, 2, 1'b1, 1'b1, 16'h0ABC);
    run_neuron("wrap4", 4, 8'hFE, 8'hFF, 1, 1, 1'b1, 1'b1, 16'h1234);
    run_neuron("zero", 0, 8'h33, 8'h44, 1, 1, 1'b1, 1'b1, 16'h5555);
    run_neuron("mac_timeout", 2, 8'h05, 8'h06, 1, 1, 1'b0, 1'b1, 16'h7777);
    run_neuron("act_timeout", 1, 8'h07, 8'h08, 3, 1, 1'b1, 1'b0, 16'h8888);
    run_neuron("lat1_single", 1, 8'h80, 8'h90, 1, 1, 1'b1, 1'b1, 16'hC0DE);

    // start held high across the whole neuron, including its DONE cycle.
    b_done = done_count;
    b_in   = rd_in_q.size();
    b_wt   = rd_wt_q.size();
    calc_lat = 1; sig_lat = 2; calc_ok = 1'b1; sig_ok = 1'b1;
    spam_val  = DW'($urandom);
    sig_value = spam_val;
    @(negedge clk);
    start = 1'b1; num_inputs = 8'd2; in_base_addr = 8'h40; wt_base_addr = 8'h50;
    k = 0;
    do begin
      @(negedge clk);
      num_inputs   = CW'($urandom);
      in_base_addr = AW'($urandom);
      wt_base_addr = AW'($urandom);
      k++;
    end while (!done && k < 500);
    check("spam done_within_budget", done, 1'b1);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    exp_result = spam_val;
    check("spam done_count", done_count - b_done, 1);
    check("spam in_reads", rd_in_q.size() - b_in, 2);
    if (b_in + 1 < rd_in_q.size()) begin
      check("spam in_addr0", rd_in_q[b_in], 32'h40);
      check("spam in_addr1", rd_in_q[b_in + 1], 32'h41);
    end
    if (b_wt < rd_wt_q.size()) check("spam wt_addr0", rd_wt_q[b_wt], 32'h50);
    check("spam neuron_result", neuron_result, spam_val);
    check("spam busy_idle", busy, 1'b0);

    // Reset during the MAC wait of the second pair.
    b_done = done_count;
    b_cs   = cs_cyc_q.size();
    calc_lat = 6; calc_ok = 1'b1; sig_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; num_inputs = 8'd3; in_base_addr = 8'h30; wt_base_addr = 8'h60;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (cs_cyc_q.size() < b_cs + 2 && k < 200) begin
      @(posedge clk);
      k++;
    end
    check("rst second_pair_reached", cs_cyc_q.size() - b_cs, 2);
    @(negedge clk);
    reset_b = 1'b0;
    #1;
    exp_result = '0;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst error", error, 1'b0);
    check("rst calc_start", calculator_start, 1'b0);
    check("rst sig_start", sigmoid_start, 1'b0);
    check("rst rd_en", {in_rd_en, wt_rd_en}, 2'b00);
    check("rst in_rd_addr", in_rd_addr, 8'h00);
    check("rst input_value", input_value, 16'h0000);
    check("rst weight_value", weight_value, 16'h0000);
    check("rst neuron_result", neuron_result, 16'h0000);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);
    check("rst no_done", done_count - b_done, 0);
    run_neuron("post_reset", 1, 8'hA0, 8'hB0, 2, 2, 1'b1, 1'b1, 16'h4321);

    // Randomized neurons.
    for (int n = 0; n < 8; n++) begin
      run_neuron("rand", int'($urandom_range(1, 8)), AW'($urandom), AW'($urandom),
                 int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                 1'b1, 1'b1, DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
